// File: rtl/toast_imem_loader.sv
// Streams encoded instruction words into IMEM through a small FIFO, appends a
// self-loop halt word and then releases the core from reset.
module toast_imem_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] HALT_WORD   = 32'h0000_006F,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS),
    localparam int unsigned CNT_W      = IDX_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load_start,
    input  logic             i_load_end,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instr_data,
    output logic             o_instr_ready,
    output logic             o_imem_wr_en,
    output logic [31:0]      o_imem_wr_addr,
    output logic [31:0]      o_imem_wr_data,
    output logic             o_core_resetn,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_word_count
);
    // state   | meaning
    // S_IDLE  | out of reset, nothing loaded, core held in reset
    // S_LOAD  | accepting words, writing FIFO head to IMEM
    // S_DRAIN | no more input, emptying FIFO into IMEM
    // S_TERM  | halt word being written
    // S_DONE  | image complete, core released
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_TERM, S_DONE} state_t;

    localparam int unsigned FP_W = $clog2(FIFO_DEPTH);
    localparam logic [FP_W:0] FIFO_FULL = (FP_W+1)'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] ACC_MAX = IDX_W'(DEPTH_WORDS - 1);

    state_t            state_q, state_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [FP_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [FP_W:0]     fifo_cnt_q, fifo_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d, acc_q, acc_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic              ready_q, ready_d, wr_en_q, wr_en_d, overflow_q, overflow_d;
    logic [31:0]       wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic              core_resetn_q, busy_q, done_q;
    logic              push, pop, flush, accept;

    always_comb begin
        state_d      = state_q;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, wr_en_q};
        accept       = (state_q == S_LOAD) && i_instr_valid && ready_q;

        if (i_load_start) begin
            state_d      = S_LOAD;
            flush        = 1'b1;
            idx_d        = '0;
            acc_d        = '0;
            overflow_d   = 1'b0;
            word_count_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) acc_d = acc_q + 1'b1;
                    if (i_instr_valid && !ready_q && fifo_cnt_q != FIFO_FULL && acc_q == ACC_MAX)
                        overflow_d = 1'b1;
                    // An empty FIFO is bypassed so a fresh word reaches IMEM on the next cycle.
                    if (fifo_cnt_q != '0) begin
                        pop       = 1'b1;
                        push      = accept;
                        wr_en_d   = 1'b1;
                        wr_data_d = fifo_mem_q[rd_ptr_q];
                    end else if (accept) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = i_instr_data;
                    end
                    if (i_load_end) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    wr_en_d = 1'b1;
                    if (fifo_cnt_q != '0) begin
                        pop       = 1'b1;
                        wr_data_d = fifo_mem_q[rd_ptr_q];
                    end else begin
                        wr_data_d = HALT_WORD;
                        state_d   = S_TERM;
                    end
                end
                S_TERM:  state_d = S_DONE;
                S_IDLE, S_DONE: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
            if (wr_en_d) begin
                wr_addr_d = BASE_ADDR + 32'({idx_q, 2'b00});
                idx_d     = idx_q + 1'b1;
            end
        end

        fifo_cnt_d = flush ? '0 : fifo_cnt_q + {{FP_W{1'b0}}, push} - {{FP_W{1'b0}}, pop};
        ready_d    = (state_d == S_LOAD) && (fifo_cnt_d != FIFO_FULL) && (acc_d < ACC_MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            word_count_q  <= '0;
            ready_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= BASE_ADDR;
            wr_data_q     <= '0;
            overflow_q    <= 1'b0;
            core_resetn_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= flush ? '0 : rd_ptr_q + {{(FP_W-1){1'b0}}, pop};
            wr_ptr_q      <= flush ? '0 : wr_ptr_q + {{(FP_W-1){1'b0}}, push};
            fifo_cnt_q    <= fifo_cnt_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            word_count_q  <= word_count_d;
            ready_q       <= ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            overflow_q    <= overflow_d;
            core_resetn_q <= (state_d == S_DONE);
            busy_q        <= (state_d == S_LOAD) || (state_d == S_DRAIN) || (state_d == S_TERM);
            done_q        <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= i_instr_data;
    end

    assign o_instr_ready  = ready_q;
    assign o_imem_wr_en   = wr_en_q;
    assign o_imem_wr_addr = wr_addr_q;
    assign o_imem_wr_data = wr_data_q;
    assign o_core_resetn  = core_resetn_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_overflow     = overflow_q;
    assign o_word_count   = word_count_q;
endmodule

// File: tb/tb_toast_imem_loader.sv
// Bench for toast_imem_loader: a full-size instance and an 8-word instance share
// stimulus; observed IMEM writes are compared against a queue-based image model.
module tb_toast_imem_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, start, lend, valid;
    logic [31:0] data;

    logic        r0, we0, cr0, busy0, done0, ov0;
    logic [31:0] wa0, wd0;
    logic [10:0] wc0;
    logic        r1, we1, cr1, busy1, done1, ov1;
    logic [31:0] wa1, wd1;
    logic [3:0]  wc1;

    toast_imem_loader dut0 (
        .clk(clk), .resetn(resetn), .i_load_start(start), .i_load_end(lend),
        .i_instr_valid(valid), .i_instr_data(data), .o_instr_ready(r0),
        .o_imem_wr_en(we0), .o_imem_wr_addr(wa0), .o_imem_wr_data(wd0),
        .o_core_resetn(cr0), .o_busy(busy0), .o_done(done0),
        .o_overflow(ov0), .o_word_count(wc0));

    toast_imem_loader #(.DEPTH_WORDS(8)) dut8 (
        .clk(clk), .resetn(resetn), .i_load_start(start), .i_load_end(lend),
        .i_instr_valid(valid), .i_instr_data(data), .o_instr_ready(r1),
        .o_imem_wr_en(we1), .o_imem_wr_addr(wa1), .o_imem_wr_data(wd1),
        .o_core_resetn(cr1), .o_busy(busy1), .o_done(done1),
        .o_overflow(ov1), .o_word_count(wc1));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    wr_t q0[$];
    wr_t q1[$];
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we0 === 1'b1) q0.push_back('{wa0, wd0, cyc});
        if (we1 === 1'b1) q1.push_back('{wa1, wd1, cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected IMEM image: first (depth-1) offered words at consecutive words, then the halt.
    task automatic model_load(input logic [31:0] w[$], input int depth);
        int n;
        n = (w.size() < depth - 1) ? w.size() : depth - 1;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back('{32'(4 * i), w[i], 0});
        exp_q.push_back('{32'(4 * n), 32'h0000_006F, 0});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_words(input logic [31:0] w[$], input int gmax, input bit end_same);
        for (int i = 0; i < w.size(); i++) begin
            valid = 1'b1;
            data  = w[i];
            lend  = end_same && (i == w.size() - 1);
            tick();
            valid = 1'b0;
            lend  = 1'b0;
            data  = $urandom;
            if (!(end_same && i == w.size() - 1)) repeat ($urandom_range(0, gmax)) tick();
        end
        if (!end_same) begin
            lend = 1'b1;
            tick();
            lend = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (done0 === 1'b1 && done1 === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; lend = 1'b0; valid = 1'b0; data = '0;
        #12;
        checks++;
        if ({r0, we0, cr0, busy0, done0, ov0} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got %b exp 000000", {r0, we0, cr0, busy0, done0, ov0});
        end
        checks++;
        if (wa0 !== 32'h0 || wd0 !== 32'h0 || wc0 !== 11'd0) begin
            failures++;
            $display("FAIL reset_values addr=%h data=%h count=%0d exp 0/0/0", wa0, wd0, wc0);
        end
        tick();
        resetn = 1'b1;
        tick();
        tick();
        checks++;
        if (r0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset ready=%b busy=%b exp 0/0", r0, busy0);
        end
    endtask

    task automatic test_basic();
        q0.delete();
        pulse_start();
        checks++;
        if (r0 !== 1'b1 || cr0 !== 1'b0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL basic_load_entry ready=%b core_rn=%b busy=%b exp 1/0/1", r0, cr0, busy0);
        end
        valid = 1'b1; data = 32'h1234_52B7;
        tick();
        checks++;
        if (we0 !== 1'b1 || wa0 !== 32'h0 || wd0 !== 32'h1234_52B7) begin
            failures++;
            $display("FAIL basic_w0 en=%b addr=%h data=%h exp 1/0/123452b7", we0, wa0, wd0);
        end
        data = 32'h6782_8293;
        tick();
        checks++;
        if (we0 !== 1'b1 || wa0 !== 32'h4 || wd0 !== 32'h6782_8293) begin
            failures++;
            $display("FAIL basic_w1 en=%b addr=%h data=%h exp 1/4/67828293", we0, wa0, wd0);
        end
        valid = 1'b0; lend = 1'b1;
        tick();
        lend = 1'b0;
        tick();
        checks++;
        if (we0 !== 1'b1 || wa0 !== 32'h8 || wd0 !== 32'h6F || cr0 !== 1'b0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL basic_term en=%b addr=%h data=%h core_rn=%b done=%b exp 1/8/6f/0/0",
                     we0, wa0, wd0, cr0, done0);
        end
        tick();
        checks++;
        if (cr0 !== 1'b1 || done0 !== 1'b1 || wc0 !== 11'd3 || we0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL basic_done core_rn=%b done=%b count=%0d en=%b busy=%b exp 1/1/3/0/0",
                     cr0, done0, wc0, we0, busy0);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] w[$];
        bit ok;
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        q0.delete(); q1.delete();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            valid = 1'b1; data = w[i];
            checks++;
            if (r0 !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready[%0d] got %b exp 1", i, r0);
            end
            tick();
        end
        valid = 1'b0; lend = 1'b1;
        tick();
        lend = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stream_timeout done=%b exp 1", done0); end
        model_load(w, 1024);
        checks++;
        if (q0.size() != exp_q.size()) begin
            failures++;
            $display("FAIL stream_count got %0d exp %0d", q0.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
            checks++;
            if (q0[i].addr !== exp_q[i].addr || q0[i].data !== exp_q[i].data ||
                (i < 16 && q0[i].cyc != q0[0].cyc + i)) begin
                failures++;
                $display("FAIL stream_wr[%0d] got %h:%h@%0d exp %h:%h@%0d", i, q0[i].addr,
                         q0[i].data, q0[i].cyc, exp_q[i].addr, exp_q[i].data, q0[0].cyc + i);
            end
        end
    endtask

    task automatic test_capacity();
        logic [31:0] w[$];
        bit ok;
        for (int i = 0; i < 10; i++) w.push_back($urandom);
        q0.delete(); q1.delete();
        pulse_start();
        drive_words(w, 0, 1'b0);
        wait_done(ok);
        repeat (3) tick();
        checks++;
        if (!ok) begin failures++; $display("FAIL cap_timeout done=%b exp 1", done1); end
        model_load(w, 8);
        checks++;
        if (q1.size() != exp_q.size()) begin
            failures++;
            $display("FAIL cap_count got %0d exp %0d", q1.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q1.size(); i++) begin
            checks++;
            if (q1[i].addr !== exp_q[i].addr || q1[i].data !== exp_q[i].data) begin
                failures++;
                $display("FAIL cap_wr[%0d] got %h:%h exp %h:%h", i, q1[i].addr, q1[i].data,
                         exp_q[i].addr, exp_q[i].data);
            end
        end
        foreach (q1[i]) begin
            checks++;
            if (q1[i].addr >= 32'h20) begin
                failures++;
                $display("FAIL cap_addr_range got %h exp below 20", q1[i].addr);
            end
        end
        checks++;
        if (ov1 !== 1'b1 || wc1 !== 4'd8 || ov0 !== 1'b0) begin
            failures++;
            $display("FAIL cap_status ovf=%b count=%0d big_ovf=%b exp 1/8/0", ov1, wc1, ov0);
        end
    endtask

    task automatic test_simul_end();
        logic [31:0] w[$];
        bit ok;
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        q0.delete(); q1.delete();
        pulse_start();
        drive_words(w, 1, 1'b1);
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL simul_timeout done=%b exp 1", done0); end
        model_load(w, 1024);
        checks++;
        if (q0.size() != 4) begin
            failures++;
            $display("FAIL simul_count got %0d exp 4", q0.size());
        end
        for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
            checks++;
            if (q0[i].addr !== exp_q[i].addr || q0[i].data !== exp_q[i].data) begin
                failures++;
                $display("FAIL simul_wr[%0d] got %h:%h exp %h:%h", i, q0[i].addr, q0[i].data,
                         exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_restart();
        logic [31:0] w[$];
        bit ok;
        w.push_back($urandom);
        pulse_start();
        valid = 1'b1; data = $urandom;
        tick();
        data = $urandom;
        tick();
        valid = 1'b0;
        pulse_start();
        q0.delete(); q1.delete();
        checks++;
        if (wc0 !== 11'd0 || we0 !== 1'b0 || cr0 !== 1'b0 || busy0 !== 1'b1 || r0 !== 1'b1) begin
            failures++;
            $display("FAIL restart_state count=%0d en=%b core_rn=%b busy=%b ready=%b exp 0/0/0/1/1",
                     wc0, we0, cr0, busy0, r0);
        end
        drive_words(w, 0, 1'b0);
        checks++;
        if (cr0 !== 1'b0) begin failures++; $display("FAIL restart_core_rn got %b exp 0", cr0); end
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL restart_timeout done=%b exp 1", done0); end
        model_load(w, 1024);
        checks++;
        if (q0.size() != exp_q.size()) begin
            failures++;
            $display("FAIL restart_count got %0d exp %0d", q0.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
            checks++;
            if (q0[i].addr !== exp_q[i].addr || q0[i].data !== exp_q[i].data) begin
                failures++;
                $display("FAIL restart_wr[%0d] got %h:%h exp %h:%h", i, q0[i].addr, q0[i].data,
                         exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = $urandom;
            tick();
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({r0, we0, cr0, busy0, done0, ov0} !== 6'b0 || wa0 !== 32'h0 || wd0 !== 32'h0 ||
            wc0 !== 11'd0) begin
            failures++;
            $display("FAIL midreset_outputs flags=%b addr=%h data=%h count=%0d exp all zero",
                     {r0, we0, cr0, busy0, done0, ov0}, wa0, wd0, wc0);
        end
        q0.delete(); q1.delete();
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        valid = 1'b0;
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || r0 !== 1'b0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_quiet writes=%0d/%0d ready=%b busy=%b exp 0/0/0/0",
                     q0.size(), q1.size(), r0, busy0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [31:0] w[$];
            int n, gmax;
            bit es, ok;
            n = $urandom_range(1, 12);
            gmax = $urandom_range(0, 2);
            es = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) w.push_back($urandom);
            q0.delete(); q1.delete();
            pulse_start();
            drive_words(w, gmax, es);
            wait_done(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_timeout[%0d] done=%b/%b exp 1/1", it, done0, done1); end
            model_load(w, 1024);
            checks++;
            if (q0.size() != exp_q.size() || wc0 !== 11'(n + 1) || ov0 !== 1'b0) begin
                failures++;
                $display("FAIL rand_big_count[%0d] writes=%0d count=%0d ovf=%b exp %0d/%0d/0",
                         it, q0.size(), wc0, ov0, exp_q.size(), n + 1);
            end
            for (int i = 0; i < exp_q.size() && i < q0.size(); i++) begin
                checks++;
                if (q0[i].addr !== exp_q[i].addr || q0[i].data !== exp_q[i].data) begin
                    failures++;
                    $display("FAIL rand_big_wr[%0d.%0d] got %h:%h exp %h:%h", it, i, q0[i].addr,
                             q0[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
            model_load(w, 8);
            checks++;
            if (q1.size() != exp_q.size() || wc1 !== 4'(exp_q.size()) || ov1 !== (n > 7)) begin
                failures++;
                $display("FAIL rand_small_count[%0d] writes=%0d count=%0d ovf=%b exp %0d/%0d/%b",
                         it, q1.size(), wc1, ov1, exp_q.size(), exp_q.size(), n > 7);
            end
            for (int i = 0; i < exp_q.size() && i < q1.size(); i++) begin
                checks++;
                if (q1[i].addr !== exp_q[i].addr || q1[i].data !== exp_q[i].data) begin
                    failures++;
                    $display("FAIL rand_small_wr[%0d.%0d] got %h:%h exp %h:%h", it, i, q1[i].addr,
                             q1[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_streaming();
        test_capacity();
        test_simul_end();
        test_restart();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/toast_imem_loader.md
# toast_imem_loader

Streams encoded RV32I instruction words into instruction memory ahead of a test run. The block accepts 32-bit words over a valid/ready handshake, buffers them, and writes them to sequential word addresses on the IMEM write port. When loading ends, it appends a self-loop halt instruction and releases the core from reset. It sits between the directed-test instruction encoders (LUI/ADDI/LI sequences) and the IMEM write port, and owns the core's reset during loading.

## Interface
Parameters:
- DEPTH_WORDS, 1024, IMEM capacity in 32-bit words (power of two, ≥ 4)
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction (word aligned)
- FIFO_DEPTH, 4, input buffer entries (power of two, ≥ 2)
- HALT_WORD, 32'h0000_006F, terminator word (JAL x0, 0)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- i_load_start  in  1  one-cycle pulse; begin or restart a load
- i_load_end  in  1  one-cycle pulse; no further words follow
- i_instr_valid  in  1  encoder word valid
- i_instr_data  in  32  encoded instruction
- o_instr_ready  out  1  word accepted when valid && ready
- o_imem_wr_en  out  1  IMEM write strobe
- o_imem_wr_addr  out  32  byte address, BASE_ADDR + 4·index
- o_imem_wr_data  out  32  word to write
- o_core_resetn  out  1  core reset, active-low
- o_busy  out  1  high in LOAD, DRAIN and TERM
- o_done  out  1  high in DONE
- o_overflow  out  1  sticky; an offered word was refused for capacity
- o_word_count  out  $clog2(DEPTH_WORDS)+1  words written to IMEM, including the terminator

## Operation
- States: IDLE, LOAD, DRAIN, TERM, DONE.
- IDLE → LOAD on i_load_start. This clears the FIFO, the write index, o_word_count and o_overflow. o_core_resetn goes low.
- LOAD: accepts words into the FIFO. The FIFO head is written to IMEM, at most one word per cycle. Accept and write may occur in the same cycle.
  - o_instr_ready = (state==LOAD) && FIFO not full && accepted_count < DEPTH_WORDS−1.
  - One slot is always reserved for the terminator.
- LOAD → DRAIN on i_load_end. A word handshaken in the same cycle is still accepted.
- DRAIN: no acceptance; keeps writing FIFO entries. DRAIN → TERM when the FIFO is empty and no write is pending.
- TERM: one cycle. Writes HALT_WORD at the next index, then moves to DONE.
- DONE: o_core_resetn high and o_done high. Holds until i_load_start, which re-enters LOAD with everything cleared.
- Capacity: if i_instr_valid is high while ready is low only because accepted_count == DEPTH_WORDS−1, set o_overflow. The word is dropped; the encoder must not rely on backpressure alone.
- i_load_start in LOAD, DRAIN or TERM aborts the load and restarts it, flushing the FIFO.
- i_load_end outside LOAD is ignored. i_load_start has priority over i_load_end.
- Index arithmetic: index is $clog2(DEPTH_WORDS) bits wide and is never allowed to wrap, because acceptance is capped. Address = BASE_ADDR + {index, 2'b00}.

## Timing
- Reset values:
  - state IDLE
  - o_instr_ready 0, o_imem_wr_en 0, o_imem_wr_addr BASE_ADDR, o_imem_wr_data 0
  - o_core_resetn 0, o_busy 0, o_done 0, o_overflow 0, o_word_count 0
- All outputs are registered.
- Latency: a word accepted in cycle N is written no earlier than cycle N+1. With the FIFO empty, it is written in exactly cycle N+1.
- Sustained throughput is 1 word/cycle; back-to-back valid in LOAD never stalls.
- o_word_count increments in the cycle after each o_imem_wr_en.
- The terminator is written one cycle after the last data write, at the earliest.
- o_core_resetn rises in the cycle after the terminator write, together with o_done.
- Reset asserted mid-load returns every output to its reset value immediately (asynchronously). No partial write completes after resetn falls.

## Test plan
- **Basic LI load.** i_load_start, then words 32'h123452B7 and 32'h67828293 on consecutive cycles, then i_load_end.
  - Required: writes 0x0→0x123452B7, 0x4→0x67828293, 0x8→0x0000006F.
  - o_word_count = 3; o_core_resetn rises one cycle after the 0x8 write.
- **Streaming.** 16 back-to-back valid words, no gaps.
  - Required: ready never drops and writes occur on 16 consecutive cycles.
  - Addresses 0x0–0x3C in order, terminator at 0x40.
- **Capacity.** With DEPTH_WORDS=8, offer 10 words.
  - Required: 7 words accepted, o_overflow = 1, terminator at 0x1C.
  - o_word_count = 8; no write at 0x20.
- **Simultaneous end.** i_load_end in the same cycle as the third word's handshake.
  - Required: the third word is written at 0x8 and the terminator at 0xC.
- **Restart.** i_load_start pulsed mid-LOAD after 2 words.
  - Required: FIFO flushed and o_word_count = 0.
  - The next word is written at 0x0, and o_core_resetn stays low.
- **Reset mid-load.** resetn dropped while words are buffered.
  - Required: all outputs at reset values in the same cycle.
  - No o_imem_wr_en until a new i_load_start.
